pingpong_frame_buffer: RTL and testbench
========================================

PINGPONG_FRAME_BUFFER -- requirements
Module: pingpong_frame_buffer

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 6, row address bits (8x8 block rows).
REQ-002 SHALL have parameter COL_WIDTH, default 7, column address bits (8x8 block columns).
REQ-003 SHALL have parameter DATA_WIDTH, default 12, pixel width (4:4:4 RGB).
REQ-004 SHALL have parameter CLEAR_EN, default 1, where 1 enables auto-clear of the new back buffer after each swap.
REQ-005 SHALL have parameter CLEAR_COLOR, default 12'h000, clear fill value (DATA_WIDTH bits).
REQ-006 SHALL have port clk  in  1  single clock for all logic.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port wr_en  in  1  tracer write strobe.
REQ-009 SHALL have port wr_row / wr_col  in  ROW_WIDTH / COL_WIDTH  write address.
REQ-010 SHALL have port wr_data  in  DATA_WIDTH  write pixel.
REQ-011 SHALL have port frame_done  in  1  one-cycle pulse, tracer finished the back frame.
REQ-012 SHALL have port wr_ready  out  1  high when writes are accepted.
REQ-013 SHALL have port wr_drop  out  1  one-cycle pulse, wr_en seen while wr_ready low.
REQ-014 SHALL have port rd_row / rd_col  in  ROW_WIDTH / COL_WIDTH  display read address.
REQ-015 SHALL have port rd_data  out  DATA_WIDTH  front-buffer pixel.
REQ-016 SHALL have port vsync_in  in  1  display frame marker; the rising edge is the swap point.
REQ-017 SHALL have port front_sel  out  1  index of the buffer being displayed.
REQ-018 SHALL have port swap_pulse  out  1  one-cycle pulse on each swap.

Function
REQ-019 SHALL hold two banks of 2^(ROW_WIDTH+COL_WIDTH) words.
- Bank address = {col,row}.
- Writes go to bank ~front_sel.
- Reads come from bank front_sel.
REQ-020 SHALL register rd_data with 1-cycle latency.
- rd_data is taken from the bank indicated by front_sel before the clock edge.
REQ-021 SHALL detect vsync_in rising edge (vs_d register) as frame_start.
REQ-022 SHALL implement FSM states WRITE, WAIT_SWAP, CLEAR.
REQ-023 WRITE: wr_ready=1.
- wr_en writes the back bank.
- frame_done moves to WAIT_SWAP.
- A wr_en in the same cycle as frame_done is still written.
REQ-024 WAIT_SWAP: wr_ready=0.
- On frame_start: toggle front_sel, pulse swap_pulse.
- Then go to CLEAR if CLEAR_EN=1, else WRITE.
REQ-025 frame_done and frame_start in the same WRITE cycle SHALL NOT swap; the swap occurs at the next frame_start.
REQ-026 CLEAR: wr_ready=0.
- clr_cnt (ROW_WIDTH+COL_WIDTH bits) writes CLEAR_COLOR to the new back bank at address clr_cnt, one word per cycle, starting from 0.
- After the all-ones address, return to WRITE; total 2^(ROW_WIDTH+COL_WIDTH) cycles.
REQ-027 wr_en while wr_ready=0 SHALL be discarded and SHALL pulse wr_drop in that cycle.
REQ-028 frame_done outside WRITE SHALL be ignored.
REQ-029 frame_start in WRITE or CLEAR SHALL NOT swap.
REQ-030 clr_cnt SHALL wrap to 0 on leaving CLEAR.

Reset
REQ-031 SHALL on rst=0, asynchronously, set:
- state=WRITE, front_sel=0, wr_ready=1;
- wr_drop=0, swap_pulse=0, rd_data=0;
- vs_d=0, clr_cnt=0.
REQ-032 SHALL NOT reset memory contents.
REQ-033 SHALL abort an in-progress CLEAR or WAIT_SWAP on reset with no further writes.

Verification (ROW_WIDTH=2, COL_WIDTH=2, DATA_WIDTH=12)
REQ-034 Write then swap:
- Stimulus: write 12'hABC at row1/col2, frame_done, vsync_in rising edge.
- Response: swap_pulse=1, front_sel=1; read row1/col2 -> rd_data=12'hABC one cycle later.
REQ-035 Clear:
- Stimulus: CLEAR_EN=1, CLEAR_COLOR=12'h00F; after a swap, wait 16 cycles; swap again.
- Response: wr_ready=0 for exactly 16 cycles; every address of the old front bank reads 12'h00F.
REQ-036 Write in WAIT_SWAP:
- Stimulus: wr_en with 12'h123 during WAIT_SWAP.
- Response: wr_drop=1; the target address is unchanged after the next swap.
REQ-037 Simultaneous frame_done and vsync edge:
- Stimulus: frame_done and vsync_in edge in the same cycle.
- Response: no swap (front_sel unchanged); the swap occurs on the following vsync edge.
REQ-038 Reset mid-clear:
- Stimulus: rst low at clr_cnt=5.
- Response: front_sel=0, wr_ready=1, rd_data=0 immediately; addresses 6..15 keep prior data.
REQ-039 Read during swap:
- Stimulus: read issued on the swap cycle.
- Response: rd_data comes from the pre-swap front bank; the next read comes from the new front bank.

Source files
------------

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: tracer fills the back bank,
// display reads the front bank, banks swap on vsync.
module pingpong_frame_buffer #(
  parameter int ROW_WIDTH = 6,
  parameter int COL_WIDTH = 7,
  parameter int DATA_WIDTH = 12,
  parameter bit CLEAR_EN = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ROW_WIDTH-1:0]  wr_row,
  input  logic [COL_WIDTH-1:0]  wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  frame_done,
  output logic                  wr_ready,
  output logic                  wr_drop,
  input  logic [ROW_WIDTH-1:0]  rd_row,
  input  logic [COL_WIDTH-1:0]  rd_col,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  vsync_in,
  output logic                  front_sel,
  output logic                  swap_pulse
);

  localparam int AW = ROW_WIDTH + COL_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    WRITE,
    WAIT_SWAP,
    CLEAR
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] bank0 [DEPTH];
  logic [DATA_WIDTH-1:0] bank1 [DEPTH];

  logic [AW-1:0] clr_cnt, clr_nxt;
  logic          front_nxt;
  logic          swap_nxt;
  logic          clr_we;
  logic          vs_d;
  logic          frame_start;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DATA_WIDTH-1:0] wdata;

  assign frame_start = vsync_in & ~vs_d;
  assign raddr = {rd_col, rd_row};
  assign we    = clr_we | (wr_ready & wr_en);
  assign waddr = clr_we ? clr_cnt : {wr_col, wr_row};
  assign wdata = clr_we ? CLEAR_COLOR : wr_data;

  // Next-state, handshake and clear-strobe decode
  always_comb begin
    state_nxt = state;
    front_nxt = front_sel;
    clr_nxt   = clr_cnt;
    swap_nxt  = 1'b0;
    wr_ready  = 1'b0;
    clr_we    = 1'b0;
    unique case (state)
      WRITE: begin
        wr_ready = 1'b1;
        if (frame_done) state_nxt = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (frame_start) begin
          front_nxt = ~front_sel;
          swap_nxt  = 1'b1;
          state_nxt = CLEAR_EN ? CLEAR : WRITE;
        end
      end
      CLEAR: begin
        clr_we  = 1'b1;
        clr_nxt = clr_cnt + AW'(1);
        if (&clr_cnt) state_nxt = WRITE;
      end
      default: state_nxt = WRITE;
    endcase
    wr_drop = wr_en & ~wr_ready;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WRITE;
      front_sel  <= 1'b0;
      clr_cnt    <= '0;
      swap_pulse <= 1'b0;
      vs_d       <= 1'b0;
    end else begin
      state      <= state_nxt;
      front_sel  <= front_nxt;
      clr_cnt    <= clr_nxt;
      swap_pulse <= swap_nxt;
      vs_d       <= vsync_in;
    end
  end

  // Back-bank write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      if (front_sel) bank0[waddr] <= wdata;
      else           bank1[waddr] <= wdata;
    end
  end

  // Front-bank registered read, bank chosen before the edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= front_sel ? bank1[raddr] : bank0[raddr];
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer
// with a 4x4 frame and clear colour 12'h00F.
module tb_pingpong_frame_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_row = '0;
  logic [1:0]  wr_col = '0;
  logic [11:0] wr_data = '0;
  logic        frame_done = 1'b0;
  logic        wr_ready;
  logic        wr_drop;
  logic [1:0]  rd_row = '0;
  logic [1:0]  rd_col = '0;
  logic [11:0] rd_data;
  logic        vsync_in = 1'b0;
  logic        front_sel;
  logic        swap_pulse;

  int errs = 0;
  int checks = 0;
  int low;

  pingpong_frame_buffer #(
    .ROW_WIDTH(2),
    .COL_WIDTH(2),
    .DATA_WIDTH(12),
    .CLEAR_EN(1'b1),
    .CLEAR_COLOR(12'h00F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_row(wr_row),
    .wr_col(wr_col),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .wr_ready(wr_ready),
    .wr_drop(wr_drop),
    .rd_row(rd_row),
    .rd_col(rd_col),
    .rd_data(rd_data),
    .vsync_in(vsync_in),
    .front_sel(front_sel),
    .swap_pulse(swap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_back(input logic [11:0] base);
    for (int a = 0; a < 16; a++) begin
      wr_en = 1'b1;
      {wr_col, wr_row} = 4'(a);
      wr_data = base + 12'(a);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_swap();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      if (wr_ready) break;
      tick();
    end
    check("ready_to", 16'(wr_ready), 16'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_front", 16'(front_sel), 16'h0);
    check("rst_ready", 16'(wr_ready), 16'h1);
    check("rst_rd", 16'(rd_data), 16'h0);
    check("rst_swap", 16'(swap_pulse), 16'h0);
    check("rst_drop", 16'(wr_drop), 16'h0);
    tick();
    tick();
    rst = 1'b1;

    // Frame 1 into bank1; ABC at row1/col2 with frame_done
    fill_back(12'h100);
    wr_en = 1'b1;
    wr_row = 2'd1;
    wr_col = 2'd2;
    wr_data = 12'hABC;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("wait_ready", 16'(wr_ready), 16'h0);
    wr_data = 12'h123;
    #1;
    check("drop_hi", 16'(wr_drop), 16'h1);
    tick();
    wr_en = 1'b0;
    #1;
    check("drop_lo", 16'(wr_drop), 16'h0);

    // First swap, then count the clear window
    rd_row = 2'd1;
    rd_col = 2'd2;
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    check("swap1_pulse", 16'(swap_pulse), 16'h1);
    check("swap1_front", 16'(front_sel), 16'h1);
    low = wr_ready ? 0 : 1;
    tick();
    check("swap1_rd", 16'(rd_data), 16'hABC);
    check("swap1_pend", 16'(swap_pulse), 16'h0);
    if (!wr_ready) low++;
    for (int i = 0; i < 40; i++) begin
      if (wr_ready) break;
      tick();
      if (!wr_ready) low++;
    end
    check("clr_len", 16'(low), 16'd16);

    // Second swap with a read issued on the swap cycle
    rd_row = 2'd1;
    rd_col = 2'd1;
    do_swap();
    check("swap2_front", 16'(front_sel), 16'h0);
    check("swap2_pulse", 16'(swap_pulse), 16'h1);
    check("rd_preswap", 16'(rd_data), 16'h105);
    tick();
    check("rd_postswap", 16'(rd_data), 16'h00F);
    for (int a = 0; a < 16; a++) begin
      {rd_col, rd_row} = 4'(a);
      tick();
      check($sformatf("clr_%0d", a), 16'(rd_data), 16'h00F);
    end
    wait_ready();

    // frame_done and vsync edge together: no swap
    fill_back(12'h200);
    frame_done = 1'b1;
    vsync_in = 1'b1;
    tick();
    frame_done = 1'b0;
    vsync_in = 1'b0;
    check("sim_front", 16'(front_sel), 16'h0);
    check("sim_pulse", 16'(swap_pulse), 16'h0);
    check("sim_ready", 16'(wr_ready), 16'h0);
    tick();
    check("sim_hold", 16'(front_sel), 16'h0);
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    check("sim_swap", 16'(front_sel), 16'h1);
    check("sim_swpp", 16'(swap_pulse), 16'h1);
    wait_ready();
    {rd_col, rd_row} = 4'd3;
    tick();
    check("sim_rd", 16'(rd_data), 16'h203);

    // Load bank0, cycle it to the back, reset mid-clear
    fill_back(12'h300);
    do_swap();
    wait_ready();
    do_swap();
    check("pre_rst_front", 16'(front_sel), 16'h1);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    #1;
    check("mid_front", 16'(front_sel), 16'h0);
    check("mid_ready", 16'(wr_ready), 16'h1);
    check("mid_rd", 16'(rd_data), 16'h0);
    tick();
    rst = 1'b1;
    for (int a = 0; a < 16; a++) begin
      if (a == 5) continue;
      {rd_col, rd_row} = 4'(a);
      tick();
      check($sformatf("keep_%0d", a), 16'(rd_data),
            a < 5 ? 16'h00F : 16'h300 + 16'(a));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
